port_pg_controller: RTL and testbench
=====================================

Name: port_pg_controller

Overview:
Power-gating controller for the four router output ports, ordered [S, N, W, E].
- Generates the epoch pulse that clears the per-port load tracker.
- At each epoch boundary, reads the tracker's per-port and router loads and decides which ports to gate or wake.
- Sequences each port through ACTIVE -> DRAIN -> INACTIVE -> WAKEUP -> ACTIVE and publishes portStatus to the tracker, the arbiter and the route-compute logic.

Parameters:
EPOCH_LEN, 256, cycles per epoch; must be >= 2.
LOAD_W, `PG_PORT_LOAD_SIZE, per-port load width.
LOW_THRESH, 8, an ACTIVE port whose epoch load is below this is a gating candidate.
HIGH_THRESH, 32, an INACTIVE port whose epoch load (productive demand) is >= this is woken.
ROUTER_HIGH, 96, router load >= this wakes every gated port.
DRAIN_CYC, 2, consecutive flit-free cycles required before a draining port gates.
WAKE_LAT, 4, power-up cycles spent in WAKEUP.
MIN_ACTIVE, 2, minimum number of ports in ACTIVE or WAKEUP at all times.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low
portLoad  input  4*LOAD_W  per-port epoch load [S,N,W,E]
routerLoad  input  LOAD_W+2  sum of the four port loads
valid  input  4  flit currently occupying the port
wakeReq  input  4  neighbour or injection request to wake a port; level-sensitive
pgEnable  output  1  one-cycle epoch pulse; clears the tracker
portStatus  output  4*`PORT_STAT_SIZE  per-port state [S,N,W,E]
gatedCount  output  3  number of ports in INACTIVE

Behaviour:
- Reset is asynchronous, active-low; clock is clk. While reset is asserted:
  - All ports are ACTIVE.
  - The epoch counter, drain counters and wake counters are 0.
  - pgEnable = 0 and gatedCount = 0.
- All outputs are registered.
- Epoch counter:
  - Counts 0..EPOCH_LEN-1 and wraps to 0.
  - pgEnable is high in the cycle where the count equals EPOCH_LEN-1.
  - The "decision edge" is the clock edge that ends that cycle. portLoad and routerLoad sampled there are the epoch totals.
- Gating selection at the decision edge:
  - Candidates are ports that are ACTIVE, have load < LOW_THRESH, and whose wakeReq is 0.
  - At most one port is moved to DRAIN per epoch: the candidate with the lowest load; ties go to the lowest index (E=0 first).
  - Selection is suppressed if (#ACTIVE + #WAKEUP) - 1 < MIN_ACTIVE.
- Per-port FSM:
  - ACTIVE -> DRAIN when selected.
  - DRAIN: the drain counter increments on each cycle with valid[i] = 0 and clears when valid[i] = 1. When the counter reaches DRAIN_CYC, go to INACTIVE.
  - DRAIN -> ACTIVE immediately if wakeReq[i] = 1 or if the router-high override fires. This abort has priority over the move to INACTIVE.
  - INACTIVE -> WAKEUP on wakeReq[i], or at the decision edge if load >= HIGH_THRESH or routerLoad >= ROUTER_HIGH.
  - WAKEUP: count WAKE_LAT cycles, then go to ACTIVE. wakeReq has no effect in WAKEUP.
- Simultaneous events: if a wake and a gate selection arrive at the same edge, the wake wins. Wakes are evaluated first; gating candidates exclude any port that is waking.
- gatedCount equals the number of ports in INACTIVE, updated on the same edge as portStatus.
- Comparisons are unsigned. The router load is zero-extended to its full width with no saturation.

Optional Feature:
PG_HYSTERESIS_EN
- Defined: a port entering ACTIVE from WAKEUP or DRAIN sets a per-port hold bit. The hold bit excludes the port from gating candidacy at the next decision edge, then clears at that edge.
- Undefined: no hold bit; the port is eligible at the next decision edge.

Decomposition:
- `ACTIVE = 2'd0, `INACTIVE = 2'd1, `DRAIN = 2'd2, `WAKEUP = 2'd3, `PORT_STAT_SIZE = 2 and `PG_PORT_LOAD_SIZE belong in globalVariable.v, the shared package. The load tracker counts only in ACTIVE or INACTIVE, which is consistent with these encodings.
- Sub-module pg_port_fsm, instantiated 4x. It contains the per-port state, drain counter, wake counter and hold bit. Inputs: select, wake, override, valid.
- The top level holds the epoch counter, the min-load selector and the MIN_ACTIVE check.

Test Plan:
1. Reset mid-epoch at count 100 -> all portStatus ACTIVE, pgEnable 0; the next pgEnable arrives 255 cycles after reset release, then every 256 cycles.
2. Loads E=3, W=3, N=20, S=40 at decision edge -> only E enters DRAIN. With valid=0, E is INACTIVE 2 cycles later and gatedCount=1. W is gated in the following epoch.
3. E in DRAIN with valid[0] toggling 1,0,1,0,0 -> stays DRAIN until two consecutive zeros, then INACTIVE. A wakeReq[0] pulse during DRAIN -> ACTIVE next cycle.
4. Two ports INACTIVE, remaining loads all 0, MIN_ACTIVE=2 -> no further DRAIN at any decision edge.
5. E INACTIVE, portLoad[E]=40 (or routerLoad=100) at decision edge -> WAKEUP for 4 cycles, then ACTIVE. With PG_HYSTERESIS_EN, load 0 at the next edge does not regate E; without it, E re-enters DRAIN.
6. wakeReq[i] and gate selection of port i at the same edge -> port i stays ACTIVE; the next-lowest candidate is selected instead.

Source files
------------

// File: rtl/port_pg_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : port_pg_controller_pkg
// Purpose  : Shared port-state encodings and widths for port power gating.
// Revision : 1.0 - initial release
// ============================================================================
package port_pg_controller_pkg;

   localparam int PORT_STAT_SIZE    = 2;
   localparam int PG_PORT_LOAD_SIZE = 8;
   localparam int NUM_PORTS         = 4;

   // The load tracker only counts in ACTIVE/INACTIVE, i.e. when bit 1 is clear.
   typedef enum logic [PORT_STAT_SIZE-1:0] {
      ACTIVE   = 2'd0,
      INACTIVE = 2'd1,
      DRAIN    = 2'd2,
      WAKEUP   = 2'd3
   } port_state_e;

   function automatic logic [2:0] count_ones4(input logic [NUM_PORTS-1:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/port_pg_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : port_pg_controller_if
// Purpose  : Load-tracker / router-side bus of the port power-gating controller.
// Revision : 1.0 - initial release
// ============================================================================
interface port_pg_controller_if #(
   parameter int LOAD_W = port_pg_controller_pkg::PG_PORT_LOAD_SIZE
);
   import port_pg_controller_pkg::*;

   logic [NUM_PORTS*LOAD_W-1:0]         portLoad;
   logic [LOAD_W+1:0]                   routerLoad;
   logic [NUM_PORTS-1:0]                valid;
   logic [NUM_PORTS-1:0]                wakeReq;
   logic                                pgEnable;
   logic [NUM_PORTS*PORT_STAT_SIZE-1:0] portStatus;
   logic [2:0]                          gatedCount;

   modport master (
      output portLoad, routerLoad, valid, wakeReq,
      input  pgEnable, portStatus, gatedCount
   );

   modport slave (
      input  portLoad, routerLoad, valid, wakeReq,
      output pgEnable, portStatus, gatedCount
   );

endinterface
`default_nettype wire

// File: rtl/port_pg_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pg_port_fsm
// Purpose  : One port's ACTIVE/DRAIN/INACTIVE/WAKEUP sequencer; optional hold
//            bit under macro PG_HYSTERESIS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pg_port_fsm
   import port_pg_controller_pkg::*;
#(
   parameter int DRAIN_CYC = 2,
   parameter int WAKE_LAT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        epoch_i,
   input  logic        select_i,
   input  logic        wake_i,
   input  logic        override_i,
   input  logic        valid_i,
   output port_state_e state_o,
   output port_state_e state_next_o,
   output logic        hold_o
);

   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam int WW = $clog2(WAKE_LAT + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC);
   localparam logic [WW-1:0] WAKE_LAST  = WW'(WAKE_LAT);

   port_state_e   state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;
   logic [WW-1:0] wake_q,  wake_d;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      wake_d  = wake_q;
      unique case (state_q)
         ACTIVE: begin
            if (select_i) begin
               state_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            // An abort beats completing the drain on the same edge.
            if (wake_i || override_i) begin
               state_d = ACTIVE;
               drain_d = '0;
            end else if (valid_i) begin
               drain_d = '0;
            end else if (drain_q + DW'(1) == DRAIN_LAST) begin
               state_d = INACTIVE;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         INACTIVE: begin
            if (wake_i || override_i) begin
               state_d = WAKEUP;
               wake_d  = '0;
            end
         end
         WAKEUP: begin
            if (wake_q + WW'(1) == WAKE_LAST) begin
               state_d = ACTIVE;
               wake_d  = '0;
            end else begin
               wake_d = wake_q + WW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ACTIVE;
         drain_q <= '0;
         wake_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         wake_q  <= wake_d;
      end
   end

`ifdef PG_HYSTERESIS_EN
   logic hold_q, hold_d;

   // Setting on re-entry wins over the epoch clear so the port sits out one full decision.
   always_comb begin
      hold_d = hold_q;
      if (epoch_i) begin
         hold_d = 1'b0;
      end
      if ((state_d == ACTIVE) && ((state_q == DRAIN) || (state_q == WAKEUP))) begin
         hold_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign hold_o = hold_q;
`else
   logic unused_epoch;
   assign unused_epoch = epoch_i;
   assign hold_o       = 1'b0;
`endif

   assign state_o      = state_q;
   assign state_next_o = state_d;

endmodule
`default_nettype wire

// File: rtl/port_pg_controller.sv
`default_nettype none
// ============================================================================
// Module   : port_pg_controller
// Purpose  : Epoch timer, min-load gating selector and four per-port power
//            sequencers; hysteresis hold under macro PG_HYSTERESIS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module port_pg_controller
   import port_pg_controller_pkg::*;
#(
   parameter int EPOCH_LEN   = 256,
   parameter int LOAD_W      = PG_PORT_LOAD_SIZE,
   parameter int LOW_THRESH  = 8,
   parameter int HIGH_THRESH = 32,
   parameter int ROUTER_HIGH = 96,
   parameter int DRAIN_CYC   = 2,
   parameter int WAKE_LAT    = 4,
   parameter int MIN_ACTIVE  = 2
) (
   input  logic                clk,
   input  logic                reset,
   port_pg_controller_if.slave pg_io
);

   localparam int EW = $clog2(EPOCH_LEN);
   localparam logic [EW-1:0]     EPOCH_LAST = EW'(EPOCH_LEN - 1);
   localparam logic [EW-1:0]     EPOCH_PRE  = EW'(EPOCH_LEN - 2);
   localparam logic [LOAD_W-1:0] LOW_T      = LOAD_W'(LOW_THRESH);
   localparam logic [LOAD_W-1:0] HIGH_T     = LOAD_W'(HIGH_THRESH);
   localparam logic [LOAD_W+1:0] RHIGH_T    = (LOAD_W + 2)'(ROUTER_HIGH);
   localparam logic [3:0]        MIN_UP     = 4'(MIN_ACTIVE);

   logic [EW-1:0]        epoch_q, epoch_d;
   logic                 pgEnable_q, pgEnable_d;
   logic [2:0]           gatedCount_q, gatedCount_d;

   logic [LOAD_W-1:0]    load [NUM_PORTS];
   port_state_e          st_q [NUM_PORTS];
   port_state_e          st_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] hold, sel, ovr, cand, waking, up, inact_d;

   logic                 decide, router_high, found, allow_gate;
   logic [1:0]           best_idx;
   logic [LOAD_W-1:0]    best_load;
   logic [2:0]           num_up;

   // pgEnable is high exactly in the last epoch cycle, so its end is the decision edge.
   assign decide      = pgEnable_q;
   assign router_high = (pg_io.routerLoad >= RHIGH_T);

   always_comb begin
      epoch_d    = (epoch_q == EPOCH_LAST) ? '0 : epoch_q + EW'(1);
      pgEnable_d = (epoch_q == EPOCH_PRE);
   end

   // Wakes are resolved first, so ports about to come back count toward MIN_ACTIVE.
   assign num_up     = count_ones4(up);
   assign allow_gate = ({1'b0, num_up} > MIN_UP);

   always_comb begin
      found     = 1'b0;
      best_idx  = 2'd0;
      best_load = '1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (cand[i] && (!found || (load[i] < best_load))) begin
            found     = 1'b1;
            best_idx  = 2'(i);
            best_load = load[i];
         end
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign load[i]    = pg_io.portLoad[i*LOAD_W +: LOAD_W];
      assign ovr[i]     = decide & (router_high | ((st_q[i] == INACTIVE) & (load[i] >= HIGH_T)));
      assign waking[i]  = ((st_q[i] == INACTIVE) | (st_q[i] == DRAIN)) & (pg_io.wakeReq[i] | ovr[i]);
      assign up[i]      = (st_q[i] == ACTIVE) | (st_q[i] == WAKEUP) | waking[i];
      assign cand[i]    = (st_q[i] == ACTIVE) & (load[i] < LOW_T) & ~pg_io.wakeReq[i] & ~hold[i];
      assign sel[i]     = decide & allow_gate & found & (best_idx == 2'(i));
      assign inact_d[i] = (st_d[i] == INACTIVE);
      assign pg_io.portStatus[i*PORT_STAT_SIZE +: PORT_STAT_SIZE] = st_q[i];

      pg_port_fsm #(
         .DRAIN_CYC (DRAIN_CYC),
         .WAKE_LAT  (WAKE_LAT)
      ) u_fsm (
         .clk          (clk),
         .reset        (reset),
         .epoch_i      (decide),
         .select_i     (sel[i]),
         .wake_i       (pg_io.wakeReq[i]),
         .override_i   (ovr[i]),
         .valid_i      (pg_io.valid[i]),
         .state_o      (st_q[i]),
         .state_next_o (st_d[i]),
         .hold_o       (hold[i])
      );
   end

   assign gatedCount_d = count_ones4(inact_d);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epoch_q      <= '0;
         pgEnable_q   <= 1'b0;
         gatedCount_q <= 3'd0;
      end else begin
         epoch_q      <= epoch_d;
         pgEnable_q   <= pgEnable_d;
         gatedCount_q <= gatedCount_d;
      end
   end

   assign pg_io.pgEnable   = pgEnable_q;
   assign pg_io.gatedCount = gatedCount_q;

endmodule
`default_nettype wire

// File: tb/tb_port_pg_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_pg_controller
// Purpose  : Self-checking bench for port_pg_controller (vector table plus
//            multi-cycle sequences); honours macro PG_HYSTERESIS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_pg_controller;
   import port_pg_controller_pkg::*;

   localparam int LW = PG_PORT_LOAD_SIZE;
`ifdef PG_HYSTERESIS_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   port_pg_controller_if #(.LOAD_W(LW)) bus ();

   port_pg_controller #(
      .EPOCH_LEN   (256),
      .LOAD_W      (LW),
      .LOW_THRESH  (8),
      .HIGH_THRESH (32),
      .ROUTER_HIGH (96),
      .DRAIN_CYC   (2),
      .WAKE_LAT    (4),
      .MIN_ACTIVE  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pg_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] st;
      logic [2:0] gc;
      logic       pg;
   } exp_t;

   typedef struct packed {
      logic [LW-1:0] e;
      logic [LW-1:0] w;
      logic [LW-1:0] n;
      logic [LW-1:0] s;
      logic [3:0]    wake;
      logic [7:0]    st;
   } vec_t;

   exp_t  sb_q[$];
   string sb_name[$];
   vec_t  vt[10];

   task automatic push_exp(input string name, input logic [7:0] st, input logic [2:0] gc, input logic pg);
      exp_t e;
      e.st = st;
      e.gc = gc;
      e.pg = pg;
      sb_q.push_back(e);
      sb_name.push_back(name);
   endtask

   task automatic pop_check();
      exp_t  e;
      string nm;
      while (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         nm = sb_name.pop_front();
         n_vec++;
         if (bus.portStatus !== e.st || bus.gatedCount !== e.gc || bus.pgEnable !== e.pg) begin
            n_err++;
            $display("FAIL %s: got status=%h gated=%0d pgEnable=%b, want status=%h gated=%0d pgEnable=%b",
                     nm, bus.portStatus, bus.gatedCount, bus.pgEnable, e.st, e.gc, e.pg);
         end
      end
   endtask

   task automatic step_expect(input string name, input logic [7:0] st, input logic [2:0] gc);
      push_exp(name, st, gc, 1'b0);
      @(posedge clk);
      @(negedge clk);
      pop_check();
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic drive(input logic [LW-1:0] e, input logic [LW-1:0] w, input logic [LW-1:0] n,
                        input logic [LW-1:0] s, input logic [3:0] wake, input logic [3:0] vld);
      bus.portLoad   = {s, n, w, e};
      bus.routerLoad = {2'b00, e} + {2'b00, w} + {2'b00, n} + {2'b00, s};
      bus.wakeReq    = wake;
      bus.valid      = vld;
   endtask

   // Counts negedges until pgEnable is seen high; always advances at least once.
   task automatic wait_pg(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.pgEnable !== 1'b1 && cyc < 400);
      if (bus.pgEnable !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL epoch_timeout: pgEnable not seen within %0d cycles", cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      drive('0, '0, '0, '0, 4'h0, 4'h0);
      #1;
      push_exp("reset_state", 8'h00, 3'd0, 1'b0);
      pop_check();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic set_vec(input int i, input logic [LW-1:0] e, input logic [LW-1:0] w, input logic [LW-1:0] n,
                          input logic [LW-1:0] s, input logic [3:0] wake, input logic [7:0] st);
      vt[i] = '{e: e, w: w, n: n, s: s, wake: wake, st: st};
   endtask

   initial begin
      int         c;
      logic [4:0] vpat;
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      drive('0, '0, '0, '0, 4'h0, 4'h0);

      // Decision-edge selection from an all-ACTIVE router: {E, W, N, S loads, wakeReq, status}.
      set_vec(0, 8'd3,  8'd3,  8'd20, 8'd40, 4'h0, 8'h02);
      set_vec(1, 8'd3,  8'd3,  8'd20, 8'd40, 4'h1, 8'h08);
      set_vec(2, 8'd10, 8'd10, 8'd10, 8'd10, 4'h0, 8'h00);
      set_vec(3, 8'd7,  8'd5,  8'd5,  8'd9,  4'h0, 8'h08);
      set_vec(4, 8'd0,  8'd0,  8'd0,  8'd0,  4'h0, 8'h02);
      set_vec(5, 8'd50, 8'd50, 8'd50, 8'd0,  4'h0, 8'h80);
      set_vec(6, 8'd8,  8'd20, 8'd20, 8'd20, 4'h0, 8'h00);
      set_vec(7, 8'd7,  8'd20, 8'd20, 8'd20, 4'h0, 8'h02);
      set_vec(8, 8'd0,  8'd0,  8'd0,  8'd0,  4'hF, 8'h00);
      set_vec(9, 8'd6,  8'd2,  8'd2,  8'd2,  4'h2, 8'h20);

      for (int i = 0; i < 10; i++) begin
         do_reset();
         wait_pg(c);
         drive(vt[i].e, vt[i].w, vt[i].n, vt[i].s, vt[i].wake, 4'h0);
         step_expect($sformatf("vec%0d", i), vt[i].st, 3'd0);
         drive('0, '0, '0, '0, 4'h0, 4'h0);
      end

      // Epoch timing, including a reset asserted mid-epoch.
      do_reset();
      wait_pg(c);
      check_int("epoch_first_after_reset", c, 255);
      wait_pg(c);
      check_int("epoch_period", c, 256);
      repeat (100) @(negedge clk);
      do_reset();
      wait_pg(c);
      check_int("epoch_after_midreset", c, 255);

      // Gate E, then W, then MIN_ACTIVE blocks further gating.
      drive(8'd3, 8'd3, 8'd20, 8'd40, 4'h0, 4'h0);
      step_expect("t2_e_drain", 8'h02, 3'd0);
      step_expect("t2_e_drain_hold", 8'h02, 3'd0);
      step_expect("t2_e_inactive", 8'h01, 3'd1);
      wait_pg(c);
      drive(8'd3, 8'd3, 8'd20, 8'd40, 4'h0, 4'h0);
      step_expect("t2_w_drain", 8'h09, 3'd1);
      step_expect("t2_w_drain_hold", 8'h09, 3'd1);
      step_expect("t2_w_inactive", 8'h05, 3'd2);
      for (int k = 0; k < 2; k++) begin
         wait_pg(c);
         drive('0, '0, '0, '0, 4'h0, 4'h0);
         step_expect($sformatf("t4_min_active%0d", k), 8'h05, 3'd2);
      end

      // High port load wakes E; then regate behaviour depends on hysteresis.
      wait_pg(c);
      drive(8'd40, 8'd0, 8'd20, 8'd20, 4'h0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         step_expect($sformatf("t5_wakeup%0d", k), 8'h07, 3'd1);
      end
      step_expect("t5_active", 8'h04, 3'd1);
      wait_pg(c);
      drive('0, '0, '0, '0, 4'h0, 4'h0);
      step_expect("t5_regate", HYST ? 8'h24 : 8'h06, 3'd1);
      step_expect("t5_regate_hold", HYST ? 8'h24 : 8'h06, 3'd1);
      step_expect("t5_regate_inactive", HYST ? 8'h14 : 8'h05, 3'd2);

      // Router-high override wakes every gated port at once.
      wait_pg(c);
      drive(8'd25, 8'd25, 8'd25, 8'd25, 4'h0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         step_expect($sformatf("t5_router_wake%0d", k), HYST ? 8'h3C : 8'h0F, 3'd0);
      end
      step_expect("t5_router_active", 8'h00, 3'd0);

      // Drain counter needs consecutive flit-free cycles; wakeReq then wakes INACTIVE E.
      do_reset();
      wait_pg(c);
      drive(8'd0, 8'd30, 8'd30, 8'd30, 4'h0, 4'h0);
      step_expect("t3_drain", 8'h02, 3'd0);
      vpat = 5'b00101;
      for (int k = 0; k < 5; k++) begin
         bus.valid = {3'b000, vpat[k]};
         step_expect($sformatf("t3_valid%0d", k), (k == 4) ? 8'h01 : 8'h02, (k == 4) ? 3'd1 : 3'd0);
      end
      bus.valid   = 4'h0;
      bus.wakeReq = 4'h1;
      for (int k = 0; k < 4; k++) begin
         step_expect($sformatf("t3_wakereq%0d", k), 8'h03, 3'd0);
      end
      step_expect("t3_wake_active", 8'h00, 3'd0);
      bus.wakeReq = 4'h0;

      // wakeReq aborts DRAIN on the very edge the drain would otherwise complete.
      do_reset();
      wait_pg(c);
      drive(8'd0, 8'd30, 8'd30, 8'd30, 4'h0, 4'h0);
      step_expect("t3b_drain", 8'h02, 3'd0);
      step_expect("t3b_drain1", 8'h02, 3'd0);
      bus.wakeReq = 4'h1;
      step_expect("t3b_abort", 8'h00, 3'd0);
      bus.wakeReq = 4'h0;
      step_expect("t3b_stays_active", 8'h00, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
